key_flow_ctrl: RTL and testbench

KEY_FLOW_CTRL -- requirements
Module: key_flow_ctrl

---
 rtl/key_flow_ctrl.sv | 153 +++++++++++++++
 tb/tb_key_flow_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_flow_ctrl.sv
// key_flow_ctrl: three push-buttons (run/stop, direction, speed) are
// synchronized and debounced, then turned into press events. The events
// drive a STOP/RUN controller and a tick generator for a flow-LED shifter.
`timescale 1ns/1ps

module key_flow_ctrl #(
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int TICK_SLOW    = 10_000_000,
  parameter int TICK_FAST    = 2_500_000
) (
  input  logic       sys_clk,
  input  logic       sys_res,
  input  logic [2:0] key,
  output logic       led_tick,
  output logic       led_dir,
  output logic       led_run,
  output logic       speed_fast
);

  localparam int              DB_W      = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [23:0]     SLOW_LAST = 24'(TICK_SLOW - 1);
  localparam logic [23:0]     FAST_LAST = 24'(TICK_FAST - 1);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [2:0]  sync1_reg;
  logic [2:0]  sync2_reg;
  logic [1:0]  warm_reg;
  logic [2:0]  press_vec;
  state_t      state_reg;
  logic [23:0] tick_cnt_reg;
  logic [23:0] tick_last;

  // Two-flop synchronizer; idles at the released (high) level.
  always_ff @(posedge sys_clk) begin
    if (sys_res) begin
      sync1_reg <= 3'b111;
      sync2_reg <= 3'b111;
    end else begin
      sync1_reg <= key;
      sync2_reg <= sync1_reg;
    end
  end

  // Marks when sync2_reg has flushed its reset value and shows the real key.
  always_ff @(posedge sys_clk) begin
    if (sys_res) begin
      warm_reg <= 2'b00;
    end else begin
      warm_reg <= {warm_reg[0], 1'b1};
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
      logic [DB_W-1:0] db_cnt_reg;
      logic            stable_reg;
      logic            stable_d_reg;
      logic            armed_reg;
      logic            press_reg;

      // Debounce: accept a new level only after it has differed from the
      // stable level for DEBOUNCE_CNT consecutive cycles.
      always_ff @(posedge sys_clk) begin
        if (sys_res) begin
          db_cnt_reg <= '0;
          stable_reg <= 1'b1;
        end else if (sync2_reg[gi] == stable_reg) begin
          db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_LAST) begin
          stable_reg <= sync2_reg[gi];
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end

      // Press pulse on a debounced 1->0 edge. A key only becomes armed once it
      // has been seen released after reset, so a key held through reset is
      // ignored until it is let go and pressed again.
      always_ff @(posedge sys_clk) begin
        if (sys_res) begin
          stable_d_reg <= 1'b1;
          armed_reg    <= 1'b0;
          press_reg    <= 1'b0;
        end else begin
          stable_d_reg <= stable_reg;
          armed_reg    <= armed_reg | (warm_reg[1] & sync2_reg[gi]);
          press_reg    <= armed_reg & stable_d_reg & ~stable_reg;
        end
      end

      assign press_vec[gi] = press_reg;
    end
  endgenerate

  assign tick_last = speed_fast ? FAST_LAST : SLOW_LAST;

  // Run/stop controller, direction/speed toggles and tick generator.
  always_ff @(posedge sys_clk) begin
    if (sys_res) begin
      state_reg    <= STOP;
      led_run      <= 1'b0;
      led_dir      <= 1'b0;
      speed_fast   <= 1'b0;
      led_tick     <= 1'b0;
      tick_cnt_reg <= '0;
    end else begin
      led_tick <= 1'b0;
      if (press_vec[1]) begin
        led_dir <= ~led_dir;
      end
      if (press_vec[2]) begin
        speed_fast <= ~speed_fast;
      end
      case (state_reg)
        STOP: begin
          tick_cnt_reg <= '0;
          if (press_vec[0]) begin
            state_reg <= RUN;
            led_run   <= 1'b1;
          end
        end
        RUN: begin
          if (press_vec[0]) begin
            // Leaving RUN suppresses any tick due on this same cycle.
            state_reg    <= STOP;
            led_run      <= 1'b0;
            tick_cnt_reg <= '0;
          end else if (press_vec[2]) begin
            // Speed change restarts the period from zero.
            tick_cnt_reg <= '0;
          end else if (tick_cnt_reg == tick_last) begin
            tick_cnt_reg <= '0;
            led_tick     <= 1'b1;
          end else begin
            tick_cnt_reg <= tick_cnt_reg + 24'd1;
          end
        end
        default: begin
          state_reg    <= STOP;
          led_run      <= 1'b0;
          tick_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_flow_ctrl.sv
// Scoreboard bench for key_flow_ctrl (DEBOUNCE_CNT=4, TICK_SLOW=8, TICK_FAST=3).
// Stimulus pushes the cycle numbers of expected ticks and of expected
// {led_run, led_dir, speed_fast} changes; a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_key_flow_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_res;
  logic [2:0] key;
  logic       led_tick;
  logic       led_dir;
  logic       led_run;
  logic       speed_fast;

  key_flow_ctrl #(
    .DEBOUNCE_CNT(4),
    .TICK_SLOW   (8),
    .TICK_FAST   (3)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_res   (sys_res),
    .key       (key),
    .led_tick  (led_tick),
    .led_dir   (led_dir),
    .led_run   (led_run),
    .speed_fast(speed_fast)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } st_ev_t;

  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  bit     mon_en = 1'b0;
  int     tick_q[$];
  st_ev_t state_q[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_state(input int c, input logic [2:0] v);
    st_ev_t ev;
    ev.cyc = c;
    ev.val = v;
    state_q.push_back(ev);
  endtask

  task automatic push_ticks(input int first, input int period, input int last);
    for (int c = first; c <= last; c += period) tick_q.push_back(c);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic hold_keys(input logic [2:0] mask, input int n);
    key = key & ~mask;
    repeat (n) @(posedge sys_clk);
    #1;
    key = key | mask;
  endtask

  // Monitor: compares every tick and every output-state change with the queues.
  logic [2:0] mon_cur;
  logic [2:0] mon_prev = 3'b000;
  logic       mon_prev_tick = 1'b0;
  st_ev_t     mon_ev;
  int         mon_exp;

  always @(negedge sys_clk) begin
    if (mon_en) begin
      mon_cur = {led_run, led_dir, speed_fast};
      if (led_tick) begin
        check("tick_back_to_back", int'(mon_prev_tick), 0);
        if (tick_q.size() == 0) begin
          check("tick_unexpected_at_cycle", cyc, -1);
        end else begin
          mon_exp = tick_q.pop_front();
          check("tick_cycle", cyc, mon_exp);
        end
      end
      if (mon_cur !== mon_prev) begin
        if (state_q.size() == 0) begin
          check("state_change_unexpected_at_cycle", cyc, -1);
        end else begin
          mon_ev = state_q.pop_front();
          check("state_change_cycle", cyc, mon_ev.cyc);
          check("state_value_run_dir_fast", int'(mon_cur), int'(mon_ev.val));
        end
      end
      mon_prev      = mon_cur;
      mon_prev_tick = led_tick;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got cycle %0d expected finish before it", cyc);
    $fatal(1, "timeout");
  end

  int t0, rr, e, s, p, q, r, u, v, w;

  initial begin
    sys_res = 1'b1;
    key     = 3'b111;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_res = 1'b0;
    check("reset_led_run", int'(led_run), 0);
    check("reset_led_dir", int'(led_dir), 0);
    check("reset_speed_fast", int'(speed_fast), 0);
    check("reset_led_tick", int'(led_tick), 0);
    mon_en = 1'b1;
    wait_until(cyc + 5);

    // Run/stop press: led_run 8 cycles after the key falls, ticks every 8.
    t0 = cyc;
    rr = t0 + 8;
    push_state(rr, 3'b100);
    push_ticks(rr + 8, 8, rr + 24);
    $display("txn run_press   key0 low at %0d, run expected at %0d", t0, rr);
    hold_keys(3'b001, 10);

    // Speed press lands when the tick counter is 5: clear, then ticks every 3.
    wait_until(rr + 22);
    e = cyc + 8;
    push_state(e, 3'b101);
    push_ticks(e + 3, 3, e + 75);
    $display("txn speed_press key2 low at %0d, fast expected at %0d", cyc, e);
    hold_keys(3'b100, 10);

    // 3-cycle glitch on direction key: rejected.
    wait_until(e + 10);
    $display("txn dir_glitch  key1 low 3 cycles at %0d, no effect expected", cyc);
    hold_keys(3'b010, 3);

    // Real direction press.
    wait_until(e + 30);
    push_state(cyc + 8, 3'b111);
    $display("txn dir_press   key1 low at %0d, dir expected at %0d", cyc, cyc + 8);
    hold_keys(3'b010, 20);

    // Run and direction together; the stop lands where a tick was due.
    wait_until(e + 70);
    s = cyc + 8;
    push_state(s, 3'b001);
    $display("txn stop_dir    key0+key1 low at %0d, stop expected at %0d", cyc, s);
    hold_keys(3'b011, 10);

    // Direction toggled while stopped is held for the next run.
    wait_until(s + 20);
    p = cyc;
    push_state(p + 8, 3'b011);
    $display("txn dir_stopped key1 low at %0d, dir expected at %0d", p, p + 8);
    hold_keys(3'b010, 20);

    wait_until(p + 40);
    q = cyc + 8;
    push_state(q, 3'b111);
    push_ticks(q + 3, 3, q + 9);
    $display("txn run_fast    key0 low at %0d, run expected at %0d", cyc, q);
    hold_keys(3'b001, 10);

    // One-cycle reset while running fast with dir=1.
    wait_until(q + 10);
    r = cyc;
    push_state(r + 1, 3'b000);
    $display("txn reset_run   reset pulse after %0d, cleared expected at %0d", r, r + 1);
    sys_res = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_res = 1'b0;

    wait_until(r + 30);
    u = cyc;
    push_state(u + 8, 3'b100);
    push_ticks(u + 16, 8, u + 16);
    $display("txn run_slow    key0 low at %0d, run expected at %0d", u, u + 8);
    hold_keys(3'b001, 10);

    // Key held low through reset: no action until released and pressed again.
    wait_until(u + 20);
    v = cyc;
    push_state(v + 1, 3'b000);
    $display("txn held_reset  key0 low with reset after %0d, no press expected", v);
    key[0]  = 1'b0;
    sys_res = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_res = 1'b0;
    repeat (29) @(posedge sys_clk);
    #1;
    key[0] = 1'b1;

    wait_until(v + 50);
    w = cyc;
    push_state(w + 8, 3'b100);
    push_ticks(w + 16, 8, w + 16);
    $display("txn repress     key0 low at %0d, run expected at %0d", w, w + 8);
    hold_keys(3'b001, 10);

    wait_until(w + 20);
    check("tick_queue_left", tick_q.size(), 0);
    check("state_queue_left", state_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
